micro_sequencer: RTL and testbench

Microprogram sequencer for the ARC microcoded CPU. It owns the microinstruction register (MIR) and the address of the microword it holds (CSAI). Each cycle it drives the next control-store address to the microcode ROM, which is combinational, 11-bit address to 41-bit word, and latches the returned word. It sits between the control-store ROM and the datapath, and handles next-address selection, DECODE dispatch, condition branches and memory wait states.

---
 rtl/mseq_pkg.sv | 47 ++++
 rtl/micro_next_addr.sv | 45 ++++
 rtl/micro_sequencer.sv | 122 ++++++++++++
 tb/tb_micro_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// Shared definitions for the ARC microprogram sequencer: microword field
// positions, branch condition encodings, sequencer states and DECODE dispatch.
package mseq_pkg;

  localparam int A_HI     = 40;
  localparam int A_LO     = 35;
  localparam int AMUX_BIT = 34;
  localparam int B_HI     = 33;
  localparam int B_LO     = 28;
  localparam int BMUX_BIT = 27;
  localparam int C_HI     = 26;
  localparam int C_LO     = 21;
  localparam int CMUX_BIT = 20;
  localparam int RD_BIT   = 19;
  localparam int WR_BIT   = 18;
  localparam int ALU_HI   = 17;
  localparam int ALU_LO   = 14;
  localparam int COND_HI  = 13;
  localparam int COND_LO  = 11;
  localparam int JADDR_HI = 10;
  localparam int JADDR_LO = 0;

  localparam int DECODE_W = 11;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Dispatch target: op selects a 256-word bank above 1024, op3 a 4-word slot.
  function automatic logic [DECODE_W-1:0] decode_addr(input logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next control-store address: sequential, conditional branch,
// unconditional jump or DECODE dispatch, chosen by the microword COND field.
module micro_next_addr
  import mseq_pkg::*;
#(
  parameter int CSAI_W = 11
) (
  input  logic [2:0]        cond,
  input  logic [CSAI_W-1:0] jaddr,
  input  logic [CSAI_W-1:0] csai,
  input  logic [31:0]       ir,
  input  logic [3:0]        psr,
  output logic [CSAI_W-1:0] next_addr
);

  logic [CSAI_W-1:0] seq_addr;
  logic              flag_n;
  logic              flag_z;
  logic              flag_v;
  logic              flag_c;
  logic              unused_ir;

  assign flag_n = psr[3];
  assign flag_z = psr[2];
  assign flag_v = psr[1];
  assign flag_c = psr[0];

  assign seq_addr  = csai + CSAI_W'(1);
  assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

  always_comb begin
    next_addr = seq_addr;
    case (cond)
      COND_N:      next_addr = flag_n ? jaddr : seq_addr;
      COND_Z:      next_addr = flag_z ? jaddr : seq_addr;
      COND_V:      next_addr = flag_v ? jaddr : seq_addr;
      COND_C:      next_addr = flag_c ? jaddr : seq_addr;
      COND_IR13:   next_addr = ir[13] ? jaddr : seq_addr;
      COND_JUMP:   next_addr = jaddr;
      COND_DECODE: next_addr = CSAI_W'(decode_addr(ir));
      default:     next_addr = seq_addr;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// ARC microprogram sequencer: owns MIR/CSAI, addresses the control-store ROM,
// stalls on pending memory operations and counts dispatched instructions.
//
// state | meaning
// BOOT  | after reset; ROM addressed at 0, MIR empty
// RUN   | one microword committed per cycle
// WAIT  | RD/WR pending; MIR/CSAI held until MemReady
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int CSAI_W = 11,
  parameter int MIR_W  = 41,
  parameter int CNT_W  = 16
) (
  input  logic              MSEQ_CLOCK_50,
  input  logic              MSEQ_RESET_InHigh,
  input  logic [MIR_W-1:0]  MSEQ_ROM_DataBUS_In,
  output logic [CSAI_W-1:0] MSEQ_ROMAddr_Out,
  input  logic [31:0]       MSEQ_IR_In,
  input  logic [3:0]        MSEQ_PSR_In,
  input  logic              MSEQ_MemReady_In,
  output logic [MIR_W-1:0]  MSEQ_MIR_Out,
  output logic              MSEQ_Valid_Out,
  output logic              MSEQ_Stall_Out,
  output logic [CNT_W-1:0]  MSEQ_InstrCount_Out
);

  state_e            state_q;
  state_e            state_d;
  logic [MIR_W-1:0]  mir_q;
  logic [CSAI_W-1:0] csai_q;
  logic [CNT_W-1:0]  count_q;
  logic [CSAI_W-1:0] next_addr;
  logic [2:0]        cond;
  logic [CSAI_W-1:0] jaddr;
  logic              mem_op;
  logic              stall;
  logic              commit;
  logic              load_mir;
  logic              rom_addr_hold;

  assign cond   = mir_q[COND_HI:COND_LO];
  assign jaddr  = CSAI_W'(mir_q[JADDR_HI:JADDR_LO]);
  assign mem_op = mir_q[RD_BIT] | mir_q[WR_BIT];

  // Same condition in RUN and WAIT: the held word still carries RD/WR.
  assign stall  = (state_q != BOOT) && mem_op && !MSEQ_MemReady_In;
  assign commit = (state_q != BOOT) && !stall;

  micro_next_addr #(
    .CSAI_W (CSAI_W)
  ) u_next_addr (
    .cond      (cond),
    .jaddr     (jaddr),
    .csai      (csai_q),
    .ir        (MSEQ_IR_In),
    .psr       (MSEQ_PSR_In),
    .next_addr (next_addr)
  );

  always_ff @(posedge MSEQ_CLOCK_50 or posedge MSEQ_RESET_InHigh) begin
    if (MSEQ_RESET_InHigh) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = stall ? WAIT : RUN;
      WAIT:    state_d = stall ? WAIT : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    MSEQ_ROMAddr_Out = '0;
    MSEQ_Valid_Out   = 1'b0;
    MSEQ_Stall_Out   = 1'b0;
    load_mir         = 1'b0;
    rom_addr_hold    = 1'b0;
    case (state_q)
      BOOT: begin
        load_mir = 1'b1;
      end
      RUN, WAIT: begin
        MSEQ_Valid_Out   = 1'b1;
        MSEQ_Stall_Out   = stall;
        load_mir         = commit;
        rom_addr_hold    = stall;
        MSEQ_ROMAddr_Out = rom_addr_hold ? csai_q : next_addr;
      end
      default: ;
    endcase
  end

  // In BOOT the ROM is addressed at 0, so the loaded word is ROM[0].
  always_ff @(posedge MSEQ_CLOCK_50 or posedge MSEQ_RESET_InHigh) begin
    if (MSEQ_RESET_InHigh) begin
      mir_q  <= '0;
      csai_q <= '0;
    end else if (load_mir) begin
      mir_q  <= MSEQ_ROM_DataBUS_In;
      csai_q <= (state_q == BOOT) ? '0 : next_addr;
    end
  end

  always_ff @(posedge MSEQ_CLOCK_50 or posedge MSEQ_RESET_InHigh) begin
    if (MSEQ_RESET_InHigh) begin
      count_q <= '0;
    end else if (commit && (cond == COND_DECODE)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign MSEQ_MIR_Out        = mir_q;
  assign MSEQ_InstrCount_Out = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed test-plan scenarios plus
// randomized ROM/IR/PSR/MemReady traffic against a behavioural model.
module tb_micro_sequencer;

  localparam int CSAI_W = 11;
  localparam int MIR_W  = 41;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MIR_W-1:0]  rom_data;
  logic [CSAI_W-1:0] rom_addr;
  logic [31:0]       ir    = '0;
  logic [3:0]        psr   = '0;
  logic              ready = 1'b1;
  logic [MIR_W-1:0]  mir;
  logic              valid;
  logic              stall;
  logic [CNT_W-1:0]  count;

  logic [MIR_W-1:0]  rom [0:2047];

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  micro_sequencer #(
    .CSAI_W (CSAI_W),
    .MIR_W  (MIR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .MSEQ_CLOCK_50       (clk),
    .MSEQ_RESET_InHigh   (rst),
    .MSEQ_ROM_DataBUS_In (rom_data),
    .MSEQ_ROMAddr_Out    (rom_addr),
    .MSEQ_IR_In          (ir),
    .MSEQ_PSR_In         (psr),
    .MSEQ_MemReady_In    (ready),
    .MSEQ_MIR_Out        (mir),
    .MSEQ_Valid_Out      (valid),
    .MSEQ_Stall_Out      (stall),
    .MSEQ_InstrCount_Out (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: sequencer as "booting or holding a word at an address", no states.
  bit         m_boot;
  logic [40:0] m_mir;
  int         m_csai;
  int         m_cnt;
  bit         m_waiting;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] mk(input logic [1:0] rw, input logic [2:0] c, input int j);
    logic [40:0] w;
    w = {9'($urandom), 32'($urandom)};
    w[19:18] = rw;
    w[13:11] = c;
    w[10:0]  = 11'(j);
    return w;
  endfunction

  function automatic int exp_next(input logic [40:0] w, input int csai,
                                  input logic [31:0] i, input logic [3:0] p);
    int j;
    int inc;
    j   = int'(w[10:0]);
    inc = (csai + 1) % 2048;
    case (w[13:11])
      3'd0:    return inc;
      3'd1:    return p[3] ? j : inc;
      3'd2:    return p[2] ? j : inc;
      3'd3:    return p[1] ? j : inc;
      3'd4:    return p[0] ? j : inc;
      3'd5:    return i[13] ? j : inc;
      3'd6:    return j;
      default: return 1024 + 256 * int'(i[31:30]) + 4 * int'(i[24:19]);
    endcase
  endfunction

  function automatic bit busy();
    return !m_boot && (m_mir[19] || m_mir[18]) && !ready;
  endfunction

  task automatic model_reset();
    m_boot    = 1'b1;
    m_mir     = '0;
    m_csai    = 0;
    m_cnt     = 0;
    m_waiting = 1'b0;
  endtask

  task automatic model_update();
    int nx;
    bit b;
    if (rst) return;
    if (m_boot) begin
      m_mir     = rom[0];
      m_csai    = 0;
      m_boot    = 1'b0;
      m_waiting = 1'b0;
      return;
    end
    b = busy();
    m_waiting = b;
    if (!b) begin
      nx = exp_next(m_mir, m_csai, ir, psr);
      if (m_mir[13:11] == 3'b111) m_cnt = (m_cnt + 1) % 65536;
      m_mir  = rom[nx];
      m_csai = nx;
    end
  endtask

  task automatic compare_all();
    int ea;
    bit b;
    b = busy();
    if (m_boot)  ea = 0;
    else if (b)  ea = m_csai;
    else         ea = exp_next(m_mir, m_csai, ir, psr);
    check("rom_addr", 64'(rom_addr), 64'(ea));
    check("mir",      64'(mir),      64'(m_mir));
    check("valid",    64'(valid),    64'(!m_boot));
    check("stall",    64'(stall),    64'(b));
    check("count",    64'(count),    64'(m_cnt));
  endtask

  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic rand_inputs();
    ir    = $urandom;
    psr   = 4'($urandom_range(15));
    ready = ($urandom_range(9) < 6);
  endtask

  initial begin
    bit found;

    for (int i = 0; i < 2048; i++) begin
      rom[i] = {9'($urandom), 32'($urandom)};
      if ($urandom_range(3) != 0) rom[i][19:18] = 2'b00;
    end
    rom[0]    = mk(2'b00, 3'd0, 5);
    rom[1]    = mk(2'b00, 3'd7, 0);
    rom[1792] = mk(2'b00, 3'd6, 10);
    rom[10]   = mk(2'b00, 3'd2, 12);
    rom[11]   = mk(2'b10, 3'd0, 99);
    rom[12]   = mk(2'b00, 3'd6, 2047);
    rom[2047] = mk(2'b00, 3'd0, 3);

    model_reset();
    #1;
    check("rst_valid", 64'(valid),    64'd0);
    check("rst_addr",  64'(rom_addr), 64'd0);
    check("rst_mir",   64'(mir),      64'd0);
    check("rst_stall", 64'(stall),    64'd0);
    check("rst_count", 64'(count),    64'd0);
    #20 rst = 1'b0;
    cycle();

    #1;
    check("boot_valid", 64'(valid),    64'd1);
    check("boot_mir",   64'(mir),      64'(rom[0]));
    check("boot_addr",  64'(rom_addr), 64'd1);
    cycle();

    ir = 32'hC000_0000;
    #1 check("decode_ld", 64'(rom_addr), 64'd1792);
    ir = 32'h8080_0000;
    #1 check("decode_addcc", 64'(rom_addr), 64'd1600);
    ir = 32'hC000_0000;
    cycle();
    #1 check("decode_count", 64'(count), 64'd1);
    cycle();

    psr = 4'b0100;
    #1 check("condz_taken", 64'(rom_addr), 64'd12);
    psr = 4'b0000;
    #1 check("condz_fall", 64'(rom_addr), 64'd11);
    cycle();

    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_stall", 64'(stall),    64'd1);
      check("wait_addr",  64'(rom_addr), 64'd11);
      check("wait_mir",   64'(mir),      64'(rom[11]));
      cycle();
    end
    ready = 1'b1;
    #1;
    check("ready_stall", 64'(stall),    64'd0);
    check("ready_addr",  64'(rom_addr), 64'd12);
    cycle();
    cycle();
    #1 check("wrap_addr", 64'(rom_addr), 64'd0);
    cycle();

    repeat (3000) begin
      rand_inputs();
      cycle();
    end

    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      rand_inputs();
      if (m_cnt != 0) ready = 1'b0;
      if (m_waiting && m_cnt != 0) found = 1'b1;
      else cycle();
    end
    check("wait_reached", 64'(found), 64'd1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("midwait_valid", 64'(valid),    64'd0);
    check("midwait_stall", 64'(stall),    64'd0);
    check("midwait_addr",  64'(rom_addr), 64'd0);
    check("midwait_mir",   64'(mir),      64'd0);
    check("midwait_count", 64'(count),    64'd0);
    cycle();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    #1 check("reboot_mir", 64'(mir), 64'(rom[0]));

    repeat (200) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
